// File: rtl/pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pong_game_ctrl                                                |
// | Purpose  : Game-level sequencer for the 8x8 Pong datapath. Produces the  |
// |            speed/move tick strobes, the playing qualifier, miss          |
// |            detection at the paddle rows, scoring and the                 |
// |            serve / rally / game-over sequence.                           |
// | Ports    : clk        system clock                                       |
// |            rst        asynchronous active-high reset                     |
// |            start      start button level (rising edge detected here)     |
// |            ball_x/y   current ball column / row (row 0 = A, 7 = B)       |
// |            pad_a/b    paddle centre columns                              |
// |            playing    1 = ball released, 0 = ball held                   |
// |            speed_tick ball direction update strobe                       |
// |            move_tick  ball position update strobe (speed_tick + 1)       |
// |            score_a/b  player scores                                      |
// |            winner     00 none, 01 A, 10 B                                |
// |            state      IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4               |
// | Options  : RALLY_SPEEDUP_EN - halve the move period after 8 rally hits   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pong_game_ctrl #(
  parameter int TICK_DIV    = 4000000,
  parameter int SERVE_TICKS = 8,
  parameter int WIN_SCORE   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] ball_x,
  input  logic [2:0] ball_y,
  input  logic [2:0] pad_a,
  input  logic [2:0] pad_b,
  output logic       playing,
  output logic       speed_tick,
  output logic       move_tick,
  output logic [2:0] score_a,
  output logic [2:0] score_b,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SERVE_TICKS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_period;
  logic          w_wrap;
  logic          r_start_q;
  logic          r_check;
  logic [2:0]    r_state;
  logic [SW-1:0] r_serve_cnt;
  logic [2:0]    r_score_a;
  logic [2:0]    r_score_b;
  logic [1:0]    r_winner;
  logic          r_scorer_b;   // 1 = last point went to B
  logic          w_start_edge;
  logic          w_hit_a;
  logic          w_hit_b;
  logic          w_eval;
  logic          w_miss_a;
  logic          w_miss_b;
  logic          w_serve_entry;
  logic          w_point_win;

  // Paddle covers pad-1..pad+1; evaluated in 4 bits so the edges never wrap.
  function automatic logic hit(input logic [2:0] x, input logic [2:0] p);
    logic [3:0] xe;
    logic [3:0] pe;
    xe = {1'b0, x};
    pe = {1'b0, p};
    return ((xe + 4'd1) >= pe) && (xe <= (pe + 4'd1));
  endfunction

  // ---------------------------------------------------------------- divider
`ifdef RALLY_SPEEDUP_EN
  logic [CW-1:0] r_period;
  logic [3:0]    r_rally;
  assign w_period = r_period;
`else
  assign w_period = CW'(TICK_DIV);
`endif

  assign w_wrap     = (r_cnt == (w_period - CW'(1)));
  assign speed_tick = (r_cnt == (w_period - CW'(2)));
  assign move_tick  = w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_start_q <= 1'b0;
      r_check   <= 1'b0;
    end else begin
      r_cnt     <= w_wrap ? '0 : r_cnt + CW'(1);
      r_start_q <= start;
      // Miss check runs one cycle after move_tick, once the ball has moved.
      r_check   <= w_wrap;
    end
  end

  // ------------------------------------------------------------- game logic
  assign w_start_edge = start & ~r_start_q;
  assign w_hit_a      = hit(ball_x, pad_a);
  assign w_hit_b      = hit(ball_x, pad_b);
  assign w_eval       = r_check && (r_state == S_PLAY);
  assign w_miss_a     = w_eval && (ball_y == 3'd0) && !w_hit_a;
  assign w_miss_b     = w_eval && (ball_y == 3'd7) && !w_hit_b;
  assign w_point_win  = r_scorer_b ? (r_score_b == 3'(WIN_SCORE))
                                   : (r_score_a == 3'(WIN_SCORE));
  assign w_serve_entry = (((r_state == S_IDLE) || (r_state == S_OVER)) && w_start_edge)
                       || ((r_state == S_POINT) && !w_point_win);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_serve_cnt <= '0;
      r_score_a   <= '0;
      r_score_b   <= '0;
      r_winner    <= 2'b00;
      r_scorer_b  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_edge) begin
            r_state     <= S_SERVE;
            r_serve_cnt <= '0;
            r_score_a   <= '0;
            r_score_b   <= '0;
            r_winner    <= 2'b00;
          end
        end
        S_SERVE: begin
          if (move_tick) begin
            if (r_serve_cnt == SW'(SERVE_TICKS - 1)) begin
              r_state <= S_PLAY;
            end else begin
              r_serve_cnt <= r_serve_cnt + SW'(1);
            end
          end
        end
        S_PLAY: begin
          if (w_miss_a) begin
            r_score_b  <= r_score_b + 3'd1;
            r_scorer_b <= 1'b1;
            r_state    <= S_POINT;
          end else if (w_miss_b) begin
            r_score_a  <= r_score_a + 3'd1;
            r_scorer_b <= 1'b0;
            r_state    <= S_POINT;
          end
        end
        S_POINT: begin
          if (w_point_win) begin
            r_state  <= S_OVER;
            r_winner <= r_scorer_b ? 2'b10 : 2'b01;
          end else begin
            r_state     <= S_SERVE;
            r_serve_cnt <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RALLY_SPEEDUP_EN
  // Rally length counts successful returns at either paddle row; it selects
  // the move period, which only changes at a divider wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rally  <= 4'd0;
      r_period <= CW'(TICK_DIV);
    end else begin
      if (w_serve_entry) begin
        r_rally <= 4'd0;
      end else if (w_eval && (((ball_y == 3'd0) && w_hit_a) || ((ball_y == 3'd7) && w_hit_b))
                   && (r_rally != 4'hF)) begin
        r_rally <= r_rally + 4'd1;
      end
      if (w_wrap) begin
        r_period <= (r_rally >= 4'd8) ? CW'(TICK_DIV / 2) : CW'(TICK_DIV);
      end
    end
  end
`endif

  assign playing = (r_state == S_PLAY);
  assign state   = r_state;
  assign score_a = r_score_a;
  assign score_b = r_score_b;
  assign winner  = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pong_game_ctrl                                             |
// | Purpose  : Directed vector bench for pong_game_ctrl                      |
// |            (TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=2).                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pong_game_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] ball_x;
  logic [2:0] ball_y;
  logic [2:0] pad_a;
  logic [2:0] pad_b;
  logic       playing;
  logic       speed_tick;
  logic       move_tick;
  logic [2:0] score_a;
  logic [2:0] score_b;
  logic [1:0] winner;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  pong_game_ctrl #(
    .TICK_DIV   (4),
    .SERVE_TICKS(2),
    .WIN_SCORE  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .pad_a     (pad_a),
    .pad_b     (pad_b),
    .playing   (playing),
    .speed_tick(speed_tick),
    .move_tick (move_tick),
    .score_a   (score_a),
    .score_b   (score_b),
    .winner    (winner),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] pa;
    logic [2:0] pb;
    logic [2:0] st;
    logic       pl;
    logic       spd;
    logic       mv;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [1:0] w;
  } vec_t;

  localparam int NV = 64;
  vec_t tbl [1:NV];

  // Row i = inputs applied before the i-th clock edge after reset release,
  // expected outputs just after that edge (divider count = i mod 4).
  task automatic fill(input int a, input int b, input logic st_in,
                      input logic [2:0] x, input logic [2:0] y,
                      input logic [2:0] pa, input logic [2:0] pb,
                      input logic [2:0] st, input logic pl,
                      input logic [2:0] sa, input logic [2:0] sb,
                      input logic [1:0] w);
    for (int i = a; i <= b; i++) begin
      tbl[i].start = st_in;
      tbl[i].x = x;   tbl[i].y = y;   tbl[i].pa = pa; tbl[i].pb = pb;
      tbl[i].st = st; tbl[i].pl = pl; tbl[i].sa = sa; tbl[i].sb = sb;
      tbl[i].w = w;
      tbl[i].spd = ((i % 4) == 2);
      tbl[i].mv  = ((i % 4) == 3);
    end
  endtask

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st/pl/spd/mv/sa/sb/w=%b_%b_%b_%b_%b_%b_%b want %b_%b_%b_%b_%b_%b_%b",
               name, act[13:11], act[10], act[9], act[8], act[7:5], act[4:2], act[1:0],
               exp[13:11], exp[10], exp[9], exp[8], exp[7:5], exp[4:2], exp[1:0]);
    end
  endtask

  function automatic logic [13:0] outs();
    return {state, playing, speed_tick, move_tick, score_a, score_b, winner};
  endfunction

  initial begin
    //    rows   start x  y  pa pb  st pl sa sb w
    fill( 1,  7, 0,    3, 3, 3, 3,  0, 0, 0, 0, 0);  // IDLE, ticks run
    fill( 8, 15, 1,    3, 3, 3, 3,  1, 0, 0, 0, 0);  // start held: one edge
    fill(16, 17, 1,    3, 3, 3, 3,  2, 1, 0, 0, 0);  // 2nd move tick -> PLAY
    fill(18, 20, 0,    3, 3, 3, 3,  2, 1, 0, 0, 0);
    fill(21, 21, 0,    5, 0, 2, 3,  3, 0, 0, 1, 0);  // miss A
    fill(22, 27, 0,    3, 3, 3, 3,  1, 0, 0, 1, 0);
    fill(28, 28, 0,    3, 3, 3, 3,  2, 1, 0, 1, 0);
    fill(29, 29, 0,    1, 0, 0, 3,  2, 1, 0, 1, 0);  // edge hit pad_a=0
    fill(30, 32, 0,    3, 3, 3, 3,  2, 1, 0, 1, 0);
    fill(33, 33, 0,    6, 7, 3, 7,  2, 1, 0, 1, 0);  // edge hit pad_b=7
    fill(34, 36, 0,    3, 3, 3, 3,  2, 1, 0, 1, 0);
    fill(37, 37, 0,    5, 7, 3, 7,  3, 0, 1, 1, 0);  // just outside -> A scores
    fill(38, 43, 0,    3, 3, 3, 3,  1, 0, 1, 1, 0);
    fill(44, 44, 0,    3, 3, 3, 3,  2, 1, 1, 1, 0);
    fill(45, 45, 0,    0, 7, 3, 7,  3, 0, 2, 1, 0);  // B misses, A reaches 2
    fill(46, 50, 0,    0, 7, 3, 7,  4, 0, 2, 1, 1);  // OVER, misses ignored
    fill(51, 55, 1,    3, 3, 3, 3,  1, 0, 0, 0, 0);  // restart clears
    fill(56, 56, 0,    3, 3, 3, 3,  2, 1, 0, 0, 0);
    fill(57, 57, 0,    7, 0, 0, 3,  3, 0, 0, 1, 0);  // A misses
    fill(58, 63, 0,    3, 3, 3, 3,  1, 0, 0, 1, 0);
    fill(64, 64, 0,    3, 3, 3, 3,  2, 1, 0, 1, 0);

    rst = 1'b1; start = 1'b0;
    ball_x = 3'd3; ball_y = 3'd3; pad_a = 3'd3; pad_b = 3'd3;
    #12;
    check("reset_hold", outs(), 14'b000_0_0_0_000_000_00);
    #8 rst = 1'b0;  // release at a falling edge

    for (int i = 1; i <= NV; i++) begin
      start  = tbl[i].start;
      ball_x = tbl[i].x;  ball_y = tbl[i].y;
      pad_a  = tbl[i].pa; pad_b  = tbl[i].pb;
      @(posedge clk);
      #1;
      check($sformatf("row%0d", i), outs(),
            {tbl[i].st, tbl[i].pl, tbl[i].spd, tbl[i].mv, tbl[i].sa, tbl[i].sb, tbl[i].w});
    end

    // Reset in the middle of a rally, between clock edges.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_play", outs(), 14'b010_1_1_0_000_001_00);
    #2 rst = 1'b1;
    #1;
    check("async_reset", outs(), 14'b000_0_0_0_000_000_00);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("post_reset_speed", outs(), 14'b000_0_1_0_000_000_00);
    @(posedge clk);
    #1;
    check("post_reset_move", outs(), 14'b000_0_0_1_000_000_00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
